// File: rtl/vector_rf_pkg.sv
// Shared types and helpers for the vector register file.
package vector_rf_pkg;

  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned LANE_W_DEF = 16;

  typedef logic [LANE_W_DEF-1:0] lane_t;
  typedef lane_t vreg_t [LANES_DEF];

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  // True when an address selects a real, writable/readable register.
  function automatic logic addr_live(input int unsigned a, input int unsigned n,
                                     input logic zero_r0);
    return (a < n) && !(zero_r0 && (a == 0));
  endfunction

endpackage

// File: rtl/vrf_clear_seq.sv
// Bulk-clear sequencer: walks idx from 0 to NREGS-1, one register per cycle.
module vrf_clear_seq
  import vector_rf_pkg::*;
#(
  parameter  int unsigned NREGS = 16,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_we    = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (idx == AW'(NREGS - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == CLEAR);
  assign clr_idx = idx;

endmodule

// File: rtl/vector_rf.sv
// Vector register file: 3 registered read ports, 1 lane-masked write port, bulk clear.
module vector_rf
  import vector_rf_pkg::*;
#(
  parameter  int unsigned NREGS   = 16,
  parameter  int unsigned LANES   = LANES_DEF,
  parameter  int unsigned LANE_W  = LANE_W_DEF,
  parameter  bit          ZERO_R0 = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS),
  localparam int unsigned DW      = LANES * LANE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] RS1,
  input  logic [AW-1:0] RS2,
  input  logic [AW-1:0] RS3,
  input  logic [AW-1:0] RD,
  input  logic [DW-1:0] WD,
  input  logic          WEV,
  input  logic [LANES-1:0] WMASK,
  input  logic          CLR,
  output logic          BUSY,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic [DW-1:0] RD3
);

  logic [DW-1:0] mem [NREGS];
  logic          busy, clr_we;
  logic [AW-1:0] clr_idx;
  logic          wr_ok;
  logic [DW-1:0] wr_old, wr_merged;
  logic [AW-1:0] rs     [3];
  logic [DW-1:0] rd_nxt [3];

  vrf_clear_seq #(.NREGS(NREGS)) u_clr (
    .clk     (clk),
    .rst     (rst),
    .clr     (CLR),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign BUSY  = busy;
  assign wr_ok = WEV && !busy && addr_live(32'(RD), NREGS, ZERO_R0);
  assign wr_old = (32'(RD) < NREGS) ? mem[RD] : '0;

  always_comb begin
    wr_merged = wr_old;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (WMASK[i]) wr_merged[i*LANE_W +: LANE_W] = WD[i*LANE_W +: LANE_W];
    end
  end

  assign rs[0] = RS1;
  assign rs[1] = RS2;
  assign rs[2] = RS3;

  // CLR is included so the read registers already hold zero on the first BUSY cycle.
  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      rd_nxt[p] = '0;
      if (!(busy || CLR) && addr_live(32'(rs[p]), NREGS, ZERO_R0)) begin
        rd_nxt[p] = (wr_ok && (rs[p] == RD)) ? wr_merged : mem[rs[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
      RD1 <= '0;
      RD2 <= '0;
      RD3 <= '0;
    end else begin
      if (clr_we)     mem[clr_idx] <= '0;
      else if (wr_ok) mem[RD]      <= wr_merged;
      RD1 <= rd_nxt[0];
      RD2 <= rd_nxt[1];
      RD3 <= rd_nxt[2];
    end
  end

endmodule

// File: tb/tb_vector_rf.sv
// Directed self-checking bench for vector_rf (NREGS=12 to exercise out-of-range addresses).
module tb_vector_rf;

  localparam int unsigned NREGS = 12;
  localparam int unsigned AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [AW-1:0] RS1, RS2, RS3, RD;
  logic [63:0] WD;
  logic        WEV;
  logic [3:0]  WMASK;
  logic        CLR;
  logic        BUSY;
  logic [63:0] RD1, RD2, RD3;

  int checks   = 0;
  int failures = 0;

  vector_rf #(.NREGS(NREGS), .LANES(4), .LANE_W(16), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst), .RS1(RS1), .RS2(RS2), .RS3(RS3), .RD(RD), .WD(WD),
    .WEV(WEV), .WMASK(WMASK), .CLR(CLR), .BUSY(BUSY), .RD1(RD1), .RD2(RD2), .RD3(RD3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [63:0] d, input logic [3:0] m);
    RD = a; WD = d; WMASK = m; WEV = 1'b1;
    tick();
    WEV = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [63:0] exp);
    RS1 = a; RS2 = a; RS3 = a;
    tick();
    check({tag, "_p1"}, RD1, exp);
    check({tag, "_p2"}, RD2, exp);
    check({tag, "_p3"}, RD3, exp);
  endtask

  function automatic logic [63:0] fill_val(input int unsigned r);
    logic [15:0] l;
    l = 16'h1000 + 16'(r);
    return {l, l, l, l};
  endfunction

  task automatic fill_all();
    for (int unsigned r = 1; r < NREGS; r++) write_reg(AW'(r), fill_val(r), 4'hF);
  endtask

  task automatic read_all_zero(input string tag);
    for (int unsigned r = 0; r < NREGS; r++) read_check(tag, AW'(r), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b0; RS1 = '0; RS2 = '0; RS3 = '0; RD = '0; WD = '0;
    WEV = 1'b0; WMASK = '0; CLR = 1'b0;

    // Reset
    tick(); tick();
    check("rst_rd1", RD1, 64'h0);
    check("rst_rd2", RD2, 64'h0);
    check("rst_rd3", RD3, 64'h0);
    check("rst_busy", {63'h0, BUSY}, 64'h0);
    rst = 1'b1;
    read_all_zero("rst_all");

    // Masked writes
    write_reg(4'd7, 64'hDDDD_CCCC_BBBB_AAAA, 4'b0101);
    read_check("mask_0101", 4'd7, 64'h0000_CCCC_0000_AAAA);
    write_reg(4'd7, 64'hDDDD_CCCC_BBBB_AAAA, 4'b1010);
    read_check("mask_1010", 4'd7, 64'hDDDD_CCCC_BBBB_AAAA);

    // Forwarding: RS1/RS2 hit the write, RS3 reads another register
    write_reg(4'd3, 64'h0004_0003_0002_0001, 4'hF);
    RS1 = 4'd3; RS2 = 4'd3; RS3 = 4'd7;
    RD = 4'd3; WD = 64'h0009_EEEE_EEEE_EEEE; WMASK = 4'b1000; WEV = 1'b1;
    tick();
    WEV = 1'b0;
    check("fwd_rd2", RD2, 64'h0009_0003_0002_0001);
    check("fwd_rd1", RD1, 64'h0009_0003_0002_0001);
    check("fwd_rd3_other", RD3, 64'hDDDD_CCCC_BBBB_AAAA);
    read_check("fwd_stored", 4'd3, 64'h0009_0003_0002_0001);

    // R0 and out-of-range
    RS1 = 4'd0; RS2 = 4'd0; RS3 = 4'd13;
    RD = 4'd0; WD = 64'hFFFF_FFFF_FFFF_FFFF; WMASK = 4'hF; WEV = 1'b1;
    tick();
    check("r0_fwd", RD1, 64'h0);
    check("oor_rs3", RD3, 64'h0);
    RS3 = 4'd13; RD = 4'd13;
    tick();
    WEV = 1'b0;
    check("oor_fwd", RD3, 64'h0);
    read_check("r0_read", 4'd0, 64'h0);
    read_check("oor_alias", 4'd1, 64'h0);
    read_check("oor_15", 4'd15, 64'h0);

    // Bulk clear with write attempts and a CLR re-pulse while busy
    fill_all();
    read_check("fill_11", 4'd11, fill_val(11));
    RS1 = 4'd11; RS2 = 4'd7; RS3 = 4'd3;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    RD = 4'd5; WD = 64'hFFFF_FFFF_FFFF_FFFF; WMASK = 4'hF; WEV = 1'b1;
    n = 0;
    while (BUSY && n < 40) begin
      n++;
      check("busy_rd1_zero", RD1, 64'h0);
      CLR = (n == 4);
      tick();
    end
    CLR = 1'b0;
    WEV = 1'b0;
    check("busy_cycles", 64'(n), 64'(NREGS));
    read_all_zero("clr_all");

    // Reset during a clear at idx=5
    fill_all();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("busy_start", {63'h0, BUSY}, 64'h1);
    for (int i = 0; i < 5; i++) tick();
    check("busy_at_idx5", {63'h0, BUSY}, 64'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid_busy", {63'h0, BUSY}, 64'h0);
    tick();
    check("rst_mid_idle", {63'h0, BUSY}, 64'h0);
    read_check("rst_mid_r11", 4'd11, 64'h0);
    read_all_zero("rst_mid_all");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
